// File: rtl/imm_gen_pipe.sv
// -----------------------------------------------------------------------------
// imm_gen_pipe
//
// RISC-V immediate generator with a 2-entry skid buffer on its output.
// The instruction word is decoded combinationally. The final immediate,
// format code and error flag are then captured in the buffer, so every
// buffered entry already holds its decoded result. The output always
// presents the oldest (main) entry. A second (skid) entry absorbs one extra
// transfer while the consumer stalls, which lets in_ready come straight
// from a register.
//
// Ports
//   clk        in   1     rising-edge clock
//   reset      in   1     asynchronous, active-high reset
//   flush      in   1     synchronous discard of all buffered entries
//   in_valid   in   1     inst_code is valid
//   in_ready   out  1     block accepts inst_code (registered)
//   inst_code  in   32    RV instruction word
//   out_valid  out  1     imm_out / imm_fmt / imm_err are valid
//   out_ready  in   1     consumer accepts the output
//   imm_out    out  XLEN  decoded immediate
//   imm_fmt    out  3     0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 SHAMT, 7 ZIMM
//   imm_err    out  1     opcode/encoding not supported for this XLEN
//
// XLEN may only be 32 or 64. SHAMT_W follows XLEN and is not meant to be
// overridden on its own.
// -----------------------------------------------------------------------------
module imm_gen_pipe #(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     inst_code,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] imm_out,
    output logic [2:0]      imm_fmt,
    output logic            imm_err
);

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam logic [2:0] FMT_NONE  = 3'd0;
    localparam logic [2:0] FMT_I     = 3'd1;
    localparam logic [2:0] FMT_S     = 3'd2;
    localparam logic [2:0] FMT_B     = 3'd3;
    localparam logic [2:0] FMT_U     = 3'd4;
    localparam logic [2:0] FMT_J     = 3'd5;
    localparam logic [2:0] FMT_SHAMT = 3'd6;
    localparam logic [2:0] FMT_ZIMM  = 3'd7;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    // Sign-extension helpers, one per immediate field width.
    function automatic logic [XLEN-1:0] sext12(input logic [11:0] v);
        return XLEN'(signed'(v));
    endfunction

    function automatic logic [XLEN-1:0] sext13(input logic [12:0] v);
        return XLEN'(signed'(v));
    endfunction

    function automatic logic [XLEN-1:0] sext21(input logic [20:0] v);
        return XLEN'(signed'(v));
    endfunction

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return XLEN'(signed'(v));
    endfunction

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            is_shift;
    logic [XLEN-1:0] dec_imm_p0;
    logic [2:0]      dec_fmt_p0;
    logic            dec_err_p0;

    assign opcode   = inst_code[6:0];
    assign funct3   = inst_code[14:12];
    assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

    // ---- stage p0: combinational decode of the incoming instruction ----
    always_comb begin
        dec_imm_p0 = '0;
        dec_fmt_p0 = FMT_NONE;
        dec_err_p0 = 1'b0;
        case (opcode)
            OPC_LOAD, OPC_JALR: begin
                dec_imm_p0 = sext12(inst_code[31:20]);
                dec_fmt_p0 = FMT_I;
            end
            OPC_OP_IMM: begin
                if (is_shift) begin
                    dec_imm_p0 = XLEN'(inst_code[20 +: SHAMT_W]);
                    dec_fmt_p0 = FMT_SHAMT;
                    // On RV32 a shamt with bit 5 set is reserved.
                    dec_err_p0 = (XLEN == 32) && inst_code[25];
                end else begin
                    dec_imm_p0 = sext12(inst_code[31:20]);
                    dec_fmt_p0 = FMT_I;
                end
            end
            OPC_OP_IMM32: begin
                if (XLEN == 64) begin
                    if (is_shift) begin
                        // Word shifts only ever use a 5-bit shamt.
                        dec_imm_p0 = XLEN'(inst_code[24:20]);
                        dec_fmt_p0 = FMT_SHAMT;
                    end else begin
                        dec_imm_p0 = sext12(inst_code[31:20]);
                        dec_fmt_p0 = FMT_I;
                    end
                end else begin
                    dec_err_p0 = 1'b1;
                end
            end
            OPC_STORE: begin
                dec_imm_p0 = sext12({inst_code[31:25], inst_code[11:7]});
                dec_fmt_p0 = FMT_S;
            end
            OPC_BRANCH: begin
                dec_imm_p0 = sext13({inst_code[31], inst_code[7], inst_code[30:25],
                                     inst_code[11:8], 1'b0});
                dec_fmt_p0 = FMT_B;
            end
            OPC_LUI, OPC_AUIPC: begin
                dec_imm_p0 = sext32({inst_code[31:12], 12'b0});
                dec_fmt_p0 = FMT_U;
            end
            OPC_JAL: begin
                dec_imm_p0 = sext21({inst_code[31], inst_code[19:12], inst_code[20],
                                     inst_code[30:21], 1'b0});
                dec_fmt_p0 = FMT_J;
            end
            OPC_SYSTEM: begin
                // CSR immediate forms carry a 5-bit zimm in the rs1 field;
                // the other SYSTEM encodings are legal but carry no immediate.
                if (funct3[2]) begin
                    dec_imm_p0 = XLEN'(inst_code[19:15]);
                    dec_fmt_p0 = FMT_ZIMM;
                end
            end
            default: begin
                dec_err_p0 = 1'b1;
            end
        endcase
    end

    // ---- stage p1: 2-entry skid buffer (main presented, skid behind it) ----
    state_t          state_q;
    state_t          state_d;
    logic            in_ready_q;
    logic            in_fire;
    logic            out_fire;
    logic            load_main;
    logic            load_skid;
    logic            move_skid;

    logic [XLEN-1:0] main_imm_p1;
    logic [2:0]      main_fmt_p1;
    logic            main_err_p1;
    logic [XLEN-1:0] skid_imm_p1;
    logic [2:0]      skid_fmt_p1;
    logic            skid_err_p1;

    assign in_fire  = in_valid && in_ready_q;
    assign out_fire = (state_q != EMPTY) && out_ready;

    always_comb begin
        state_d   = state_q;
        load_main = 1'b0;
        load_skid = 1'b0;
        move_skid = 1'b0;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        load_main = 1'b1;
                        state_d   = ONE;
                    end
                end
                ONE: begin
                    case ({in_fire, out_fire})
                        2'b10: begin
                            load_skid = 1'b1;
                            state_d   = FULL;
                        end
                        2'b01: state_d = EMPTY;
                        2'b11: load_main = 1'b1;
                        default: ;
                    endcase
                end
                FULL: begin
                    // in_ready is low here, so no new entry can arrive.
                    if (out_fire) begin
                        move_skid = 1'b1;
                        state_d   = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            // Registered ready: it looks ahead at the next state.
            in_ready_q <= (state_d != FULL);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_imm_p1 <= '0;
            main_fmt_p1 <= FMT_NONE;
            main_err_p1 <= 1'b0;
            skid_imm_p1 <= '0;
            skid_fmt_p1 <= FMT_NONE;
            skid_err_p1 <= 1'b0;
        end else begin
            if (load_main) begin
                main_imm_p1 <= dec_imm_p0;
                main_fmt_p1 <= dec_fmt_p0;
                main_err_p1 <= dec_err_p0;
            end else if (move_skid) begin
                main_imm_p1 <= skid_imm_p1;
                main_fmt_p1 <= skid_fmt_p1;
                main_err_p1 <= skid_err_p1;
            end
            if (load_skid) begin
                skid_imm_p1 <= dec_imm_p0;
                skid_fmt_p1 <= dec_fmt_p0;
                skid_err_p1 <= dec_err_p0;
            end
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != EMPTY);
    assign imm_out   = main_imm_p1;
    assign imm_fmt   = main_fmt_p1;
    assign imm_err   = main_err_p1;

endmodule

// File: tb/tb_imm_gen_pipe.sv
module tb_imm_gen_pipe;

    localparam int XLEN = 32;

    logic            clk;
    logic            reset;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     inst_code;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] imm_out;
    logic [2:0]      imm_fmt;
    logic            imm_err;

    int checks = 0;
    int errors = 0;

    imm_gen_pipe #(.XLEN(XLEN)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .inst_code (inst_code),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .imm_out   (imm_out),
        .imm_fmt   (imm_fmt),
        .imm_err   (imm_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; sample point is 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; inst_code = '0;
        step(); step();
        checks++;
        if ({out_valid, in_ready, imm_out, imm_fmt, imm_err} !== {1'b0, 1'b0, 32'h0, 3'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: got v=%b rdy=%b imm=%h fmt=%0d err=%b, want all zero",
                     out_valid, in_ready, imm_out, imm_fmt, imm_err);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready_before_edge: got %b want 0", in_ready);
        end
        step();
        checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            errors++;
            $display("FAIL reset_ready_after_edge: got rdy=%b v=%b want rdy=1 v=0", in_ready, out_valid);
        end
    endtask

    task automatic test_addi();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        inst_code = 32'hFFF00093;
        step();
        in_valid = 1'b0;
        checks++;
        if ({out_valid, imm_out, imm_fmt, imm_err} !== {1'b1, 32'hFFFFFFFF, 3'd1, 1'b0}) begin
            errors++;
            $display("FAIL addi: got v=%b imm=%h fmt=%0d err=%b want v=1 imm=ffffffff fmt=1 err=0",
                     out_valid, imm_out, imm_fmt, imm_err);
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL addi_drain: got v=%b want 0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        inst_code = 32'h123450B7;
        step();
        inst_code = 32'hFFDFF0EF;
        checks++;
        if ({out_valid, imm_out, imm_fmt, imm_err} !== {1'b1, 32'h12345000, 3'd4, 1'b0}) begin
            errors++;
            $display("FAIL b2b_lui: got v=%b imm=%h fmt=%0d err=%b want v=1 imm=12345000 fmt=4 err=0",
                     out_valid, imm_out, imm_fmt, imm_err);
        end
        step();
        in_valid = 1'b0;
        checks++;
        if ({out_valid, imm_out, imm_fmt, imm_err} !== {1'b1, 32'hFFFFFFFC, 3'd5, 1'b0}) begin
            errors++;
            $display("FAIL b2b_jal: got v=%b imm=%h fmt=%0d err=%b want v=1 imm=fffffffc fmt=5 err=0",
                     out_valid, imm_out, imm_fmt, imm_err);
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drain: got v=%b want 0", out_valid);
        end
    endtask

    // Three instructions against a stalled consumer, then release.
    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        inst_code = 32'h00500093;          // addi  -> 5, I
        step();
        checks++;
        if ({in_ready, out_valid, imm_out} !== {1'b1, 1'b1, 32'h00000005}) begin
            errors++;
            $display("FAIL bp_first: got rdy=%b v=%b imm=%h want rdy=1 v=1 imm=00000005",
                     in_ready, out_valid, imm_out);
        end
        inst_code = 32'hFE11AC23;          // sw    -> -8, S
        step();
        checks++;
        if ({in_ready, out_valid, imm_out} !== {1'b0, 1'b1, 32'h00000005}) begin
            errors++;
            $display("FAIL bp_full: got rdy=%b v=%b imm=%h want rdy=0 v=1 imm=00000005",
                     in_ready, out_valid, imm_out);
        end
        inst_code = 32'hFE2088E3;          // beq   -> -16, B
        step();
        checks++;
        if ({in_ready, out_valid, imm_out, imm_fmt} !== {1'b0, 1'b1, 32'h00000005, 3'd1}) begin
            errors++;
            $display("FAIL bp_held: got rdy=%b v=%b imm=%h fmt=%0d want rdy=0 v=1 imm=00000005 fmt=1",
                     in_ready, out_valid, imm_out, imm_fmt);
        end
        out_ready = 1'b1;
        step();
        checks++;
        if ({in_ready, out_valid, imm_out, imm_fmt} !== {1'b1, 1'b1, 32'hFFFFFFF8, 3'd2}) begin
            errors++;
            $display("FAIL bp_second: got rdy=%b v=%b imm=%h fmt=%0d want rdy=1 v=1 imm=fffffff8 fmt=2",
                     in_ready, out_valid, imm_out, imm_fmt);
        end
        step();
        in_valid = 1'b0;
        checks++;
        if ({out_valid, imm_out, imm_fmt} !== {1'b1, 32'hFFFFFFF0, 3'd3}) begin
            errors++;
            $display("FAIL bp_third: got v=%b imm=%h fmt=%0d want v=1 imm=fffffff0 fmt=3",
                     out_valid, imm_out, imm_fmt);
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_drain: got v=%b want 0 (duplicate entry)", out_valid);
        end
    endtask

    task automatic test_decode_table();
        logic [31:0] insts [13] = '{32'hFFF12083, 32'h008080E7, 32'h7FF0F093, 32'hFE11AC23,
                                    32'hFE2088E3, 32'hFFFFF097, 32'h4030D093, 32'h3002D0F3,
                                    32'h00000073, 32'h0010009B, 32'h00000000, 32'h02009093,
                                    32'h002081B3};
        logic [31:0] imms  [13] = '{32'hFFFFFFFF, 32'h00000008, 32'h000007FF, 32'hFFFFFFF8,
                                    32'hFFFFFFF0, 32'hFFFFF000, 32'h00000003, 32'h00000005,
                                    32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000,
                                    32'h00000000};
        logic [2:0]  fmts  [13] = '{3'd1, 3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd6, 3'd7,
                                    3'd0, 3'd0, 3'd0, 3'd6, 3'd0};
        logic        errs  [13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                    1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        out_ready = 1'b1;
        for (int i = 0; i < 13; i++) begin
            in_valid  = 1'b1;
            inst_code = insts[i];
            step();
            checks++;
            if ({out_valid, imm_out, imm_fmt, imm_err} !== {1'b1, imms[i], fmts[i], errs[i]}) begin
                errors++;
                $display("FAIL decode[%0d] inst=%h: got v=%b imm=%h fmt=%0d err=%b want v=1 imm=%h fmt=%0d err=%b",
                         i, insts[i], out_valid, imm_out, imm_fmt, imm_err, imms[i], fmts[i], errs[i]);
            end
        end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        inst_code = 32'h00500093;
        step();
        inst_code = 32'hFE11AC23;
        step();
        in_valid = 1'b0;
        #3;
        reset = 1'b1;
        #1;
        checks++;
        if ({out_valid, in_ready, imm_out, imm_fmt, imm_err} !== {1'b0, 1'b0, 32'h0, 3'd0, 1'b0}) begin
            errors++;
            $display("FAIL async_reset: got v=%b rdy=%b imm=%h fmt=%0d err=%b want all zero before edge",
                     out_valid, in_ready, imm_out, imm_fmt, imm_err);
        end
        step();
        reset     = 1'b0;
        in_valid  = 1'b1;
        inst_code = 32'h123450B7;
        step();
        in_valid = 1'b0;
        checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            errors++;
            $display("FAIL async_reset_release: got rdy=%b v=%b want rdy=1 v=0", in_ready, out_valid);
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_inflight: got v=%b want 0", out_valid);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        inst_code = 32'h00500093;
        step();
        inst_code = 32'hFE11AC23;
        step();
        flush     = 1'b1;
        inst_code = 32'h123450B7;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            errors++;
            $display("FAIL flush_full: got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready);
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_full_drop: got v=%b want 0", out_valid);
        end
        in_valid  = 1'b1;
        inst_code = 32'h00500093;
        step();
        flush     = 1'b1;
        out_ready = 1'b1;
        inst_code = 32'hFFFFF097;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_one: got v=%b want 0", out_valid);
        end
        in_valid  = 1'b1;
        inst_code = 32'h123450B7;
        step();
        in_valid = 1'b0;
        checks++;
        if ({out_valid, imm_out, imm_fmt} !== {1'b1, 32'h12345000, 3'd4}) begin
            errors++;
            $display("FAIL flush_resume: got v=%b imm=%h fmt=%0d want v=1 imm=12345000 fmt=4",
                     out_valid, imm_out, imm_fmt);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_addi();
        test_back_to_back();
        test_backpressure();
        test_decode_table();
        test_async_reset();
        test_flush();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/imm_gen_pipe.md
IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 Parameter XLEN, default 32, datapath width of the immediate output; the only legal values SHALL be 32 and 64.
REQ-002 Parameter SHAMT_W, default $clog2(XLEN), shift-amount width; it SHALL NOT be overridden independently of XLEN.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 flush  input  1  synchronous discard of all buffered entries.
REQ-006 in_valid  input  1  inst_code is valid this cycle.
REQ-007 in_ready  output  1  block accepts inst_code this cycle.
REQ-008 inst_code  input  32  RV instruction word.
REQ-009 out_valid  output  1  imm_out, imm_fmt and imm_err are valid.
REQ-010 out_ready  input  1  consumer accepts the output this cycle.
REQ-011 imm_out  output  XLEN  decoded immediate.
REQ-012 imm_fmt  output  3  format code: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 SHAMT, 7 ZIMM.
REQ-013 imm_err  output  1  opcode or encoding not supported for this XLEN.

Function
REQ-014 Transfer SHALL occur when valid and ready are both high; latency from input transfer to out_valid SHALL be exactly 1 cycle when the buffer is empty.
REQ-015 Storage SHALL be a 2-entry skid buffer (main and skid) with states EMPTY, ONE and FULL; output SHALL always present the main entry.
REQ-016 in_ready SHALL be a registered signal, high in EMPTY and ONE and low in FULL.
REQ-017 Transitions: EMPTY+in -> ONE; ONE+in and no out -> FULL; ONE+out and no in -> EMPTY; ONE+in+out -> ONE with the new entry in main; FULL+out -> ONE with skid moved to main.
REQ-018 Ordering SHALL be strict FIFO; no entry SHALL be lost or duplicated under any combination of in_valid and out_ready.
REQ-019 flush SHALL force state EMPTY on the next edge and drop any simultaneous input; flush SHALL have priority over in/out.
REQ-020 Load (0000011), JALR (1100111) and OP-IMM (0010011) with funct3 not 001/101 SHALL yield sign-extended inst[31:20], fmt I.
REQ-021 OP-IMM with funct3 001/101 SHALL yield inst[20+SHAMT_W-1:20] zero-extended, fmt SHAMT; with XLEN=32 and inst[25]=1, imm_err SHALL be 1.
REQ-022 OP-IMM-32 (0011011): with XLEN=64, funct3 001/101 SHALL yield the zero-extended 5-bit shamt inst[24:20], fmt SHAMT, and other funct3 values SHALL yield sign-extended inst[31:20], fmt I; with XLEN=32, the result SHALL be imm 0, fmt NONE, imm_err 1.
REQ-023 S-type (0100011) SHALL yield sign-extended {inst[31:25],inst[11:7]}.
REQ-024 B-type (1100011) SHALL yield sign-extended {inst[31],inst[7],inst[30:25],inst[11:8],0}.
REQ-025 LUI (0110111) and AUIPC (0010111) SHALL yield {inst[31:12],12'b0} sign-extended to XLEN, fmt U.
REQ-026 JAL (1101111) SHALL yield sign-extended {inst[31],inst[19:12],inst[20],inst[30:21],0}, fmt J.
REQ-027 SYSTEM (1110011) with funct3[2]=1 SHALL yield inst[19:15] zero-extended, fmt ZIMM; other SYSTEM funct3 values SHALL yield 0, fmt NONE, imm_err 0.
REQ-028 Any other opcode SHALL yield imm 0, fmt NONE, imm_err 1.
REQ-029 Decode SHALL be combinational before the buffer, so buffered entries hold final results.

Reset
REQ-030 While reset is high, state SHALL be EMPTY, out_valid 0, in_ready 0, imm_out 0, imm_fmt 0 and imm_err 0, applied asynchronously.
REQ-031 in_ready SHALL rise on the first clk edge after reset deasserts; an entry in flight during reset SHALL be discarded.

Verification
REQ-032 ADDI 0xFFF00093, out_ready=1 -> next cycle imm_out=0xFFFFFFFF (XLEN=32) or all-ones (XLEN=64), fmt=1, err=0.
REQ-033 LUI 0x123450B7 then JAL 0xFFDFF0EF back-to-back -> imm_out 0x12345000 fmt 4, then 0xFFFFFFFC fmt 5 on consecutive cycles.
REQ-034 out_ready=0, present three instructions -> two accepted, in_ready=0 after the 2nd; raise out_ready -> all three emerge in order with no gaps or loss.
REQ-035 inst_code 0x00000000 -> imm_out=0, fmt=0, err=1; SLLI 0x02009093 with XLEN=32 -> err=1, fmt=6.
REQ-036 Assert reset asynchronously while FULL -> out_valid=0 before the next clk edge; assert flush while FULL -> EMPTY next cycle and the simultaneous input dropped.
